// File: rtl/reg_bus_master_if.sv
// rtl/reg_bus_master_if.sv - host request and register-bus signal bundle for reg_bus_master
interface reg_bus_master_if #(
    parameter int WIDTH  = 16,
    parameter int NREG   = 8,
    parameter int ADDR_W = 3
);
    logic              req;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wdata;
    logic              ready;
    logic              done;
    logic              err;
    logic [WIDTH-1:0]  rdata;
    logic [NREG-1:0]   sel_n;
    logic              we_n;
    logic [WIDTH-1:0]  bus_wdata;
    logic              bus_oe;
    logic [WIDTH-1:0]  bus_rdata;

    modport master (
        input  req, wr, addr, wdata, bus_rdata,
        output ready, done, err, rdata, sel_n, we_n, bus_wdata, bus_oe
    );

    modport slave (
        output req, wr, addr, wdata, bus_rdata,
        input  ready, done, err, rdata, sel_n, we_n, bus_wdata, bus_oe
    );
endinterface

// File: rtl/reg_bus_master.sv
// rtl/reg_bus_master.sv - register bus initiator: host requests to select/write-enable/read sequences
module reg_bus_master #(
    parameter int WIDTH  = 16,
    parameter int NREG   = 8,
    parameter int ADDR_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    reg_bus_master_if.master     bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WRITE   = 3'd1;
    localparam logic [2:0] S_RSETUP  = 3'd2;
    localparam logic [2:0] S_RCAPT   = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    logic [2:0]       r_state;
    logic [NREG-1:0]  r_sel_n;
    logic             r_we_n;
    logic             r_oe;
    logic             r_done;
    logic             r_err;
    logic [WIDTH-1:0] r_bus_wdata;
    logic [WIDTH-1:0] r_rdata;

    logic             w_addr_bad;
    logic [NREG-1:0]  w_sel_dec;

    assign w_addr_bad = (32'(bus.addr) >= 32'(NREG));
    assign w_sel_dec  = ~(NREG'(1) << bus.addr);

    // Bus controls are registered so the register bank sees glitch-free strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sel_n     <= '1;
            r_we_n      <= 1'b1;
            r_oe        <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_bus_wdata <= '0;
            r_rdata     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req) begin
                        r_err <= w_addr_bad;
                        if (w_addr_bad) begin
                            r_done  <= 1'b1;
                            r_state <= S_RELEASE;
                        end else if (bus.wr) begin
                            r_sel_n     <= w_sel_dec;
                            r_we_n      <= 1'b0;
                            r_oe        <= 1'b1;
                            r_bus_wdata <= bus.wdata;
                            r_state     <= S_WRITE;
                        end else begin
                            r_sel_n <= w_sel_dec;
                            r_state <= S_RSETUP;
                        end
                    end
                end
                S_WRITE: begin
                    r_sel_n <= '1;
                    r_we_n  <= 1'b1;
                    r_oe    <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_RELEASE;
                end
                S_RSETUP: begin
                    r_state <= S_RCAPT;
                end
                S_RCAPT: begin
                    // Select is still held this cycle, so the slave output has had a full cycle to settle.
                    r_rdata <= bus.bus_rdata;
                    r_sel_n <= '1;
                    r_done  <= 1'b1;
                    r_state <= S_RELEASE;
                end
                S_RELEASE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_sel_n <= '1;
                    r_we_n  <= 1'b1;
                    r_oe    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = (r_state == S_IDLE);
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.rdata     = r_rdata;
    assign bus.sel_n     = r_sel_n;
    assign bus.we_n      = r_we_n;
    assign bus.bus_oe    = r_oe;
    assign bus.bus_wdata = r_bus_wdata;
endmodule

// File: tb/tb_reg_bus_master.sv
// tb/tb_reg_bus_master.sv - randomized self-checking bench for reg_bus_master with a register bank model
module tb_reg_bus_master;
    localparam int WIDTH  = 16;
    localparam int NREG   = 8;
    localparam int ADDR_W = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    reg_bus_master_if #(.WIDTH(WIDTH), .NREG(NREG), .ADDR_W(ADDR_W)) bus ();

    reg_bus_master #(.WIDTH(WIDTH), .NREG(NREG), .ADDR_W(ADDR_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank: the slaves live on the bus and are not reset by the master.
    logic [WIDTH-1:0] slv [NREG];
    logic             slave_drive;
    int               sel_idx;

    always_comb begin
        sel_idx = 0;
        for (int i = 0; i < NREG; i++)
            if (!bus.sel_n[i]) sel_idx = i;
        slave_drive   = (bus.sel_n != '1) && bus.we_n;
        bus.bus_rdata = slave_drive ? slv[sel_idx] : '0;
    end

    always @(posedge clk) begin
        if ((bus.sel_n != '1) && !bus.we_n)
            slv[sel_idx] <= bus.bus_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        check("mon_onehot", 32'($countones(~bus.sel_n) <= 1), 32'd1);
        check("mon_contention", 32'(bus.bus_oe && slave_drive), 32'd0);
        check("mon_oe_we", 32'(bus.bus_oe), 32'(!bus.we_n));
    end

    // Reference model: register contents and the last valid read result.
    logic [WIDTH-1:0] mdl [NREG];
    logic [WIDTH-1:0] mdl_rdata;

    // Called at posedge+1 with the master idle; returns at posedge+1 with it idle again.
    task automatic xfer(input logic w, input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        int          lat;
        int          exp_lat;
        logic        bad;
        logic [NREG-1:0] exp_sel;
        bad      = (int'(a) >= NREG);
        exp_sel  = '1;
        if (!bad) exp_sel[a[2:0]] = 1'b0;
        exp_lat  = bad ? 1 : (w ? 2 : 3);
        check("ready_idle", 32'(bus.ready), 32'd1);
        bus.req   = 1'b1;
        bus.wr    = w;
        bus.addr  = a;
        bus.wdata = d;
        @(posedge clk); #1;
        bus.req = 1'b0;
        lat = 1;
        while (!bus.done && lat < 10) begin
            check("busy_ready", 32'(bus.ready), 32'd0);
            if (w) begin
                check("wr_sel", 32'(bus.sel_n), 32'(exp_sel));
                check("wr_we", 32'(bus.we_n), 32'd0);
                check("wr_oe", 32'(bus.bus_oe), 32'd1);
                check("wr_data", 32'(bus.bus_wdata), 32'(d));
            end else begin
                check("rd_sel", 32'(bus.sel_n), 32'(exp_sel));
                check("rd_we", 32'(bus.we_n), 32'd1);
                check("rd_oe", 32'(bus.bus_oe), 32'd0);
            end
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("done", 32'(bus.done), 32'd1);
        check("err", 32'(bus.err), 32'(bad));
        check("rel_sel", 32'(bus.sel_n), 32'hFF);
        check("rel_we", 32'(bus.we_n), 32'd1);
        check("rel_oe", 32'(bus.bus_oe), 32'd0);
        if (!bad) begin
            if (w) mdl[a[2:0]] = d;
            else   mdl_rdata   = mdl[a[2:0]];
        end
        check("rdata", 32'(bus.rdata), 32'(mdl_rdata));
        @(posedge clk); #1;
        check("done_pulse", 32'(bus.done), 32'd0);
    endtask

    int               cyc;
    logic [WIDTH-1:0] d;
    logic [ADDR_W-1:0] a;
    logic             w;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        mdl_rdata = '0;
        rst       = 1'b0;
        bus.req   = 1'b0;
        bus.wr    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;

        #3 rst = 1'b1;
        #1;
        check("rst_sel", 32'(bus.sel_n), 32'hFF);
        check("rst_we", 32'(bus.we_n), 32'd1);
        check("rst_oe", 32'(bus.bus_oe), 32'd0);
        check("rst_rdata", 32'(bus.rdata), 32'd0);
        check("rst_wdata", 32'(bus.bus_wdata), 32'd0);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < NREG; i++) begin
            d = 16'($urandom);
            xfer(1'b1, 4'(i), d);
        end

        xfer(1'b1, 4'd2, 16'hAAAA);
        check("slv2", 32'(slv[2]), 32'h0000AAAA);
        xfer(1'b0, 4'd2, 16'h0);
        check("rd2", 32'(bus.rdata), 32'h0000AAAA);
        xfer(1'b0, 4'd9, 16'h0);
        check("inv_rdata", 32'(bus.rdata), 32'h0000AAAA);

        bus.req   = 1'b1;
        bus.wr    = 1'b1;
        bus.addr  = 4'd0;
        bus.wdata = 16'h1234;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!bus.done && cyc < 10);
        check("hold_wr_lat", 32'(cyc), 32'd2);
        bus.wr = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!bus.done && cyc < 10);
        check("hold_rd_lat", 32'(cyc), 32'd4);
        check("hold_rd_data", 32'(bus.rdata), 32'h00001234);
        bus.req   = 1'b0;
        mdl[0]    = 16'h1234;
        mdl_rdata = 16'h1234;
        @(posedge clk); #1;
        check("hold_idle", 32'(bus.ready), 32'd1);

        bus.req  = 1'b1;
        bus.wr   = 1'b0;
        bus.addr = 4'd2;
        @(posedge clk); #1;
        bus.req = 1'b0;
        check("abort_rsetup_sel", 32'(bus.sel_n), 32'hFB);
        #2 rst = 1'b1;
        #1;
        check("abort_sel", 32'(bus.sel_n), 32'hFF);
        check("abort_we", 32'(bus.we_n), 32'd1);
        check("abort_oe", 32'(bus.bus_oe), 32'd0);
        check("abort_rdata", 32'(bus.rdata), 32'd0);
        check("abort_ready", 32'(bus.ready), 32'd1);
        check("abort_done", 32'(bus.done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mdl_rdata = '0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("abort_nodone", 32'(bus.done), 32'd0);
        end
        xfer(1'b0, 4'd2, 16'h0);

        for (int i = 0; i < 60; i++) begin
            w = 1'($urandom_range(0, 1));
            a = 4'($urandom_range(0, 11));
            d = 16'($urandom);
            xfer(w, a, d);
        end
        for (int i = 0; i < NREG; i++)
            check("final_slv", 32'(slv[i]), 32'(mdl[i]));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
